// File: rtl/div_iterative_unit_pkg.sv
// Shared multdiv constants: divider step counts, step-counter state encoding,
// and the phase decode of that counter.
package div_iterative_unit_pkg;

  localparam int unsigned DIV_STEPS       = 32;
  localparam int unsigned DIV_FINISH_STEP = DIV_STEPS + 1;

  localparam int unsigned STEP_IDLE       = 0;
  localparam int unsigned STEP_ITER_FIRST = 1;
  localparam int unsigned STEP_ITER_LAST  = DIV_STEPS;
  localparam int unsigned STEP_FINISH     = DIV_FINISH_STEP;

  typedef enum logic [1:0] {
    PH_IDLE,
    PH_ITERATE,
    PH_FINISH
  } div_phase_e;

endpackage

// File: rtl/div_iterative_unit_if.sv
// Issue/writeback-side signals of the iterative divider.
interface div_iterative_unit_if #(
  parameter int WIDTH = 32
) ();

  logic             ctrl_div;
  logic [WIDTH-1:0] data_operandA;
  logic [WIDTH-1:0] data_operandB;
  logic [WIDTH-1:0] data_result;
  logic             data_exception;
  logic             data_resultRDY;
  logic             busy;

  modport master (
    output ctrl_div, data_operandA, data_operandB,
    input  data_result, data_exception, data_resultRDY, busy
  );

  modport slave (
    input  ctrl_div, data_operandA, data_operandB,
    output data_result, data_exception, data_resultRDY, busy
  );

endinterface

// File: rtl/div_iterative_unit_div_step.sv
// One restoring shift-subtract iteration on unsigned magnitudes.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] div_i,
  output logic [WIDTH:0]   rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH+1:0] rem_sh;
  logic [WIDTH+1:0] div_ext;
  logic [WIDTH:0]   diff;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    rem_sh  = {rem_i, quo_i[WIDTH-1]};
    div_ext = {2'b00, div_i};
    // The remainder stays below 2*D, so the difference fits in WIDTH+1 bits.
    diff    = rem_sh[WIDTH:0] - div_ext[WIDTH:0];
    rem_o   = rem_sh[WIDTH:0];
    quo_o   = {quo_i[WIDTH-2:0], 1'b0};
    if (rem_sh >= div_ext) begin
      rem_o    = diff;
      quo_o[0] = 1'b1;
    end
  end

endmodule

// File: rtl/div_iterative_unit.sv
// Sequential signed divider: the step counter encodes IDLE/ITERATE/FINISH,
// one shift-subtract per cycle, sign fix-up and single-cycle RDY on FINISH.
module div_iterative_unit
  import div_iterative_unit_pkg::*;
#(
  parameter int WIDTH  = DIV_STEPS,
  parameter int STEP_W = 6
) (
  input  logic                 clock,
  input  logic                 reset,
  div_iterative_unit_if.slave  bus
);

  localparam logic [STEP_W-1:0] STEP_ZERO  = STEP_W'(STEP_IDLE);
  localparam logic [STEP_W-1:0] STEP_FIRST = STEP_W'(STEP_ITER_FIRST);
  localparam logic [STEP_W-1:0] STEP_FIN   = STEP_W'(WIDTH + 1);

  logic [STEP_W-1:0] step_q, step_d;
  logic [WIDTH:0]    rem_q, rem_d;
  logic [WIDTH-1:0]  quo_q, quo_d;
  logic [WIDTH-1:0]  dvs_q, dvs_d;
  logic [WIDTH-1:0]  result_q, result_d;
  logic              sign_q, sign_d;
  logic              divzero_q, divzero_d;
  logic              exc_q, exc_d;
  logic              rdy_q, rdy_d;
  logic              busy_q, busy_d;

  logic [WIDTH:0]    rem_nx;
  logic [WIDTH-1:0]  quo_nx;
  logic [WIDTH-1:0]  abs_a, abs_b;
  div_phase_e        phase;

  div_step #(.WIDTH(WIDTH)) u_div_step (
    .rem_i (rem_q),
    .quo_i (quo_q),
    .div_i (dvs_q),
    .rem_o (rem_nx),
    .quo_o (quo_nx)
  );

  // Unsigned magnitudes: the most negative value maps onto itself.
  assign abs_a = bus.data_operandA[WIDTH-1] ? -bus.data_operandA : bus.data_operandA;
  assign abs_b = bus.data_operandB[WIDTH-1] ? -bus.data_operandB : bus.data_operandB;

  always_comb begin
    phase = PH_IDLE;
    if (step_q == STEP_FIN)       phase = PH_FINISH;
    else if (step_q != STEP_ZERO) phase = PH_ITERATE;
  end

  always_comb begin
    step_d    = step_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    sign_d    = sign_q;
    divzero_d = divzero_q;
    result_d  = result_q;
    exc_d     = exc_q;
    rdy_d     = 1'b0;

    // A start strobe wins over any in-flight step, including FINISH.
    if (bus.ctrl_div) begin
      rem_d     = '0;
      quo_d     = abs_a;
      dvs_d     = abs_b;
      sign_d    = bus.data_operandA[WIDTH-1] ^ bus.data_operandB[WIDTH-1];
      divzero_d = (bus.data_operandB == '0);
      step_d    = STEP_FIRST;
    end else begin
      case (phase)
        PH_ITERATE: begin
          rem_d  = rem_nx;
          quo_d  = quo_nx;
          step_d = step_q + STEP_W'(1);
        end
        PH_FINISH: begin
          result_d = divzero_q ? '0 : (sign_q ? -quo_q : quo_q);
          exc_d    = divzero_q;
          rdy_d    = 1'b1;
          step_d   = STEP_ZERO;
        end
        default: ;
      endcase
    end

    busy_d = (step_d != STEP_ZERO);
  end

  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      step_q    <= STEP_ZERO;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      sign_q    <= 1'b0;
      divzero_q <= 1'b0;
      result_q  <= '0;
      exc_q     <= 1'b0;
      rdy_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      step_q    <= step_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      sign_q    <= sign_d;
      divzero_q <= divzero_d;
      result_q  <= result_d;
      exc_q     <= exc_d;
      rdy_q     <= rdy_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.data_result    = result_q;
  assign bus.data_exception = exc_q;
  assign bus.data_resultRDY = rdy_q;
  assign bus.busy           = busy_q;

endmodule
